env_pdm_out: RTL
================

// Module: env_pdm_out
// PURPOSE
//   Audio output stage between the pulse-wave voice and the audio PMOD pin (uio_out[7]).
//   Shapes the 1-bit voice with an 8-bit ADSR envelope, stepped on the shared 1 MHz tick.
//   Converts the shaped sample to a 1-bit PDM stream with a first-order sigma-delta
//   modulator running at the full clk rate.
// PARAMETERS
//   RATE_SHIFT  4  step interval = (rate+1) << RATE_SHIFT ticks
// PORTS
//   clk            in   1  system clock (25 MHz)
//   rst_n          in   1  reset, asynchronous, active-low
//   tick_1mhz      in   1  one-clk enable pulse, 1 MHz (pulse_1MHz)
//   gate           in   1  note gate; high = key held
//   voice_in       in   1  raw pulse-wave voice output
//   attack_rate    in   4  attack step rate (0 = fastest)
//   decay_rate     in   4  decay step rate
//   sustain_level  in   8  sustain target level
//   release_rate   in   4  release step rate
//   pdm_out        out  1  PDM bitstream to pin, registered
//   env_level      out  8  current envelope level
//   env_state      out  3  current ADSR state (package encoding)
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     state=IDLE, env_level=0, step counter=0, sigma-delta acc=0, pdm_out=0, gate_q=0.
//   Gate edge detect:
//     gate_q <= gate each clk.
//     Rise (gate & ~gate_q) in any state -> ATTACK next clk.
//     Retrigger keeps the current env_level; it is not cleared.
//   Step timer:
//     Counts tick_1mhz pulses; a step fires when count == ((rate+1)<<RATE_SHIFT)-1 and a tick is present.
//     rate is the input for the current state. Counter clears on a step and on every state change.
//     Rate inputs are sampled live; a change mid-interval takes effect against the current count.
//     If the count already exceeds the new limit, the step fires on the next tick.
//   FSM (priority: rise > gate-low > level checks > step):
//     IDLE:    env=0; leave only on rise.
//     ATTACK:  on step env+1; env==255 -> DECAY (no wrap past 255).
//     DECAY:   env<=sustain_level, checked every clk -> SUSTAIN with no decrement;
//              otherwise on step env-1.
//     SUSTAIN: hold env; a later change to sustain_level does not move env.
//     RELEASE: on step env-1; env==0 -> IDLE (no wrap below 0).
//     gate==0 in ATTACK/DECAY/SUSTAIN -> RELEASE next clk.
//     sustain_level=255: DECAY -> SUSTAIN the clk after entry.
//   Sample and modulator:
//     sample = voice_in ? env_level : 8'd0.
//     {c, acc} <= acc + sample (9-bit sum) every clk; pdm_out <= c.
//     Ones density over any 256 consecutive clks with constant sample = sample/256, exactly.
//   Latency:
//     gate rise at clk N -> env_state=ATTACK after edge N+1.
//     A sample change reaches the pdm_out density one clk later.
//   Reset mid-operation: all outputs return to reset values immediately, not clock-gated.
// STRUCTURE
//   Shared audio package: ENV_IDLE=3'd0, ENV_ATTACK=3'd1, ENV_DECAY=3'd2,
//     ENV_SUSTAIN=3'd3, ENV_RELEASE=3'd4; ENV_MAX=8'd255.
//   One sub-module, sigma_delta_1st (8-bit in, 1-bit out, clk/rst_n).
//   The envelope FSM and step timer stay in this module.
// TESTING
//   1 Tick every 25 clk, attack_rate=0, gate 0->1: env +1 every 16 ticks;
//     255 after 4080 ticks, then state DECAY.
//   2 sustain=128, decay_rate=1: env falls 1 per 32 ticks to 128, state SUSTAIN.
//     Gate low -> RELEASE, env reaches 0, state IDLE.
//   3 Held env=255, voice_in=1: exactly 255 ones per 256 clk.
//     env=64: exactly 64 ones. voice_in=0: pdm_out constant 0.
//   4 In RELEASE at env=100, gate rise: ATTACK next clk, env still 100, counter cleared.
//   5 sustain_level=255 with gate held: DECAY for exactly one clk, then SUSTAIN at 255.
//   6 rst_n low mid-ATTACK between clk edges: pdm_out, env_level and env_state are 0 before the next edge.

Source files
------------

// File: rtl/env_pdm_out_pkg.sv
// Shared audio definitions: ADSR state encoding and envelope limits.
package env_pdm_out_pkg;
  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_e;

  localparam logic [7:0] ENV_MAX = 8'd255;
  localparam int         RATE_W  = 4;
  localparam int         LVL_W   = 8;
endpackage

// File: rtl/env_pdm_out_if.sv
// Control/observation bundle of the envelope + PDM audio output stage.
interface env_pdm_out_if;
  import env_pdm_out_pkg::*;
  logic              gate;
  logic              voice_in;
  logic [RATE_W-1:0] attack_rate;
  logic [RATE_W-1:0] decay_rate;
  logic [LVL_W-1:0]  sustain_level;
  logic [RATE_W-1:0] release_rate;
  logic              pdm_out;
  logic [LVL_W-1:0]  env_level;
  logic [2:0]        env_state;

  modport master (
    output gate, voice_in, attack_rate, decay_rate, sustain_level, release_rate,
    input  pdm_out, env_level, env_state
  );
  modport slave (
    input  gate, voice_in, attack_rate, decay_rate, sustain_level, release_rate,
    output pdm_out, env_level, env_state
  );
endinterface

// File: rtl/env_pdm_out_sd.sv
// First-order sigma-delta: carry out of an accumulating adder, so the ones
// density over any 2^W clocks of constant input equals din / 2^W exactly.
module sigma_delta_1st #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic         dout
);
  logic [W-1:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      dout  <= 1'b0;
    end else begin
      {dout, acc_q} <= {1'b0, acc_q} + {1'b0, din};
    end
  end
endmodule

// File: rtl/env_pdm_out.sv
// ADSR envelope stepped on the 1 MHz tick, shaping the 1-bit voice before
// sigma-delta conversion to the PDM audio pin.
module env_pdm_out
  import env_pdm_out_pkg::*;
#(
  parameter int RATE_SHIFT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_1mhz,
  env_pdm_out_if.slave    bus
);
  localparam int CNT_W = RATE_W + RATE_SHIFT;

  env_state_e        state_q, state_d;
  logic [LVL_W-1:0]  env_q, env_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, limit;
  logic [RATE_W-1:0] rate;
  logic              gate_q, rise, step;
  logic [LVL_W-1:0]  sample;
  logic              pdm;

  always_comb begin
    rate = '0;
    unique case (state_q)
      ENV_ATTACK:  rate = bus.attack_rate;
      ENV_DECAY:   rate = bus.decay_rate;
      ENV_RELEASE: rate = bus.release_rate;
      default:     rate = '0;
    endcase
  end

  // ((rate+1) << RATE_SHIFT) - 1 is just rate with RATE_SHIFT ones appended.
  // >= so a live rate drop below the current count fires on the next tick.
  assign limit = {rate, {RATE_SHIFT{1'b1}}};
  assign step  = tick_1mhz && (cnt_q >= limit);
  assign rise  = bus.gate & ~gate_q;

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (rise) begin
      state_d = ENV_ATTACK;
    end else begin
      unique case (state_q)
        ENV_IDLE:    env_d = '0;
        ENV_ATTACK:
          if (!bus.gate)            state_d = ENV_RELEASE;
          else if (env_q == ENV_MAX) state_d = ENV_DECAY;
          else if (step)            env_d   = env_q + 8'd1;
        ENV_DECAY:
          if (!bus.gate)                      state_d = ENV_RELEASE;
          else if (env_q <= bus.sustain_level) state_d = ENV_SUSTAIN;
          else if (step)                      env_d   = env_q - 8'd1;
        ENV_SUSTAIN:
          if (!bus.gate) state_d = ENV_RELEASE;
        ENV_RELEASE:
          if (env_q == '0) state_d = ENV_IDLE;
          else if (step)   env_d   = env_q - 8'd1;
        default: begin
          state_d = ENV_IDLE;
          env_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(tick_1mhz);
    if (rise || step || (state_d != state_q)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENV_IDLE;
      env_q   <= '0;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      cnt_q   <= cnt_d;
      gate_q  <= bus.gate;
    end
  end

  assign sample = bus.voice_in ? env_q : '0;

  sigma_delta_1st #(.W(LVL_W)) u_sd (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sample),
    .dout  (pdm)
  );

  assign bus.pdm_out   = pdm;
  assign bus.env_level = env_q;
  assign bus.env_state = state_q;
endmodule
